mul32_scoreboard: RTL

Self-checking result scoreboard for the pipelined 32-bit Dadda multiplier (mul32p). It sits directly downstream of the multiplier in the hardware self-tester. It receives each operand pair and mode when it is issued to the multiplier, delays them by the multiplier latency, and compares the multiplier output against a reference product. It runs fixed-length test campaigns, counts vectors and errors, and captures the first failing vector for debug readout.

---
 rtl/mul32_scoreboard.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mul32_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul32_scoreboard: checks pipelined 32x32 multiplier results against a      |
// | reference product, counts vectors/errors and captures the first failure.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mul32_scoreboard #(
  parameter int LAT  = 8,
  parameter int NVEC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_mode,
  input  logic [63:0] dut_res,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] vec_count,
  output logic [31:0] err_count,
  output logic        fail_valid,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic        fail_mode,
  output logic [63:0] fail_exp,
  output logic [63:0] fail_got
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Every stage except the output one; empty means nothing is left behind the check.
  localparam logic [LAT-1:0] UPSTREAM_MASK = {LAT{1'b1}} >> 1;
  localparam logic [31:0]    LAST_ISSUE    = 32'(NVEC - 1);

  state_t          state_q, state_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [LAT-1:0]  mode_q, mode_d;
  logic [31:0]     a_q [LAT];
  logic [31:0]     a_d [LAT];
  logic [31:0]     b_q [LAT];
  logic [31:0]     b_d [LAT];
  logic [31:0]     issue_q, issue_d;
  logic [31:0]     vec_q, vec_d;
  logic [31:0]     err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [31:0]     fail_a_q, fail_a_d;
  logic [31:0]     fail_b_q, fail_b_d;
  logic            fail_mode_q, fail_mode_d;
  logic [63:0]     fail_exp_q, fail_exp_d;
  logic [63:0]     fail_got_q, fail_got_d;

  logic            accept;
  logic            chk_vld;
  logic            mismatch;
  logic signed [63:0] op_a, op_b, exp_res;

  // Extending both operands to 64 bits makes one signed multiply serve both modes.
  always_comb begin
    op_a    = {{32{mode_q[LAT-1] & a_q[LAT-1][31]}}, a_q[LAT-1]};
    op_b    = {{32{mode_q[LAT-1] & b_q[LAT-1][31]}}, b_q[LAT-1]};
    exp_res = op_a * op_b;
  end

  assign accept   = (state_q == S_RUN) && in_valid;
  assign chk_vld  = vld_q[LAT-1];
  assign mismatch = chk_vld && (exp_res != dut_res);

  always_comb begin
    vld_d[0]  = accept;
    mode_d[0] = in_mode;
    a_d[0]    = in_a;
    b_d[0]    = in_b;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      mode_d[i] = mode_q[i-1];
      a_d[i]    = a_q[i-1];
      b_d[i]    = b_q[i-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_mode_d  = fail_mode_q;
    fail_exp_d   = fail_exp_q;
    fail_got_d   = fail_got_q;

    if (chk_vld) begin
      vec_d = vec_q + 32'd1;
    end
    if (mismatch) begin
      err_d = (err_q == 32'hFFFF_FFFF) ? err_q : err_q + 32'd1;
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_a_d     = a_q[LAT-1];
        fail_b_d     = b_q[LAT-1];
        fail_mode_d  = mode_q[LAT-1];
        fail_exp_d   = exp_res;
        fail_got_d   = dut_res;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          issue_d      = '0;
          vec_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_mode_d  = 1'b0;
          fail_exp_d   = '0;
          fail_got_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          issue_d = issue_q + 32'd1;
          if (issue_q == LAST_ISSUE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((vld_q & UPSTREAM_MASK) == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vld_q        <= '0;
      issue_q      <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_mode_q  <= 1'b0;
      fail_exp_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      issue_q      <= issue_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_mode_q  <= fail_mode_d;
      fail_exp_q   <= fail_exp_d;
      fail_got_q   <= fail_got_d;
    end
  end

  // Operand payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    for (int i = 0; i < LAT; i++) begin
      a_q[i] <= a_d[i];
      b_q[i] <= b_d[i];
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (err_q == 32'd0);
  assign vec_count  = vec_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_mode  = fail_mode_q;
  assign fail_exp   = fail_exp_q;
  assign fail_got   = fail_got_q;

endmodule
`default_nettype wire
